// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : display_pkg
//  Description : Shared widths, position-field offsets, FSM encoding and the
//                snapshot record used by the frame commit controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  localparam int GRID_W  = 64;
  localparam int POS_W   = 18;
  localparam int SCORE_W = 8;

  // Bit offsets of the 3-bit coordinates inside a packed position word.
  localparam int B1X = 0;
  localparam int B1Y = 3;
  localparam int B2X = 6;
  localparam int B2Y = 9;
  localparam int B3X = 12;
  localparam int B3Y = 15;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HELD = 1'b1
  } fsm_state_t;

  // One complete game-state snapshot as seen by the renderer.
  typedef struct packed {
    logic [GRID_W-1:0]  grid;
    logic [GRID_W-1:0]  blk1;
    logic [GRID_W-1:0]  blk2;
    logic [GRID_W-1:0]  blk3;
    logic [POS_W-1:0]   pos;
    logic [SCORE_W-1:0] score;
    logic               game_over;
  } snapshot_t;

endpackage : display_pkg
`default_nettype wire

// File: rtl/vsync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : vsync_edge_det
//  Description : Normalises vga_vs to an active-high level and emits a
//                one-cycle strobe when vertical sync becomes active.
//  Revision    : 1.0 - initial release
// ============================================================================
module vsync_edge_det #(
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic vga_vs,
  output logic vs_start
);

  logic vs_act;
  logic vs_act_q;

  generate
    if (VS_ACTIVE_LOW != 0) begin : g_active_low
      assign vs_act = ~vga_vs;
    end else begin : g_active_high
      assign vs_act = vga_vs;
    end
  endgenerate

  // History resets to "inactive" so a sync already active at release is not
  // mistaken for a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vs_act_q <= 1'b0;
    else       vs_act_q <= vs_act;
  end

  assign vs_start = vs_act & ~vs_act_q;

endmodule : vsync_edge_det
`default_nettype wire

// File: rtl/frame_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_commit_ctrl
//  Description : Stages game-state snapshots and commits them to the display
//                registers at vertical-sync start; also provides a frame
//                counter and the game-over blink phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_commit_ctrl
  import display_pkg::*;
#(
  parameter int BLINK_FRAMES  = 30,
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vga_vs,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [GRID_W-1:0]  upd_grid,
  input  logic [GRID_W-1:0]  upd_blk1,
  input  logic [GRID_W-1:0]  upd_blk2,
  input  logic [GRID_W-1:0]  upd_blk3,
  input  logic [POS_W-1:0]   upd_pos,
  input  logic [SCORE_W-1:0] upd_score,
  input  logic               upd_game_over,
  output logic [GRID_W-1:0]  disp_grid,
  output logic [GRID_W-1:0]  disp_blk1,
  output logic [GRID_W-1:0]  disp_blk2,
  output logic [GRID_W-1:0]  disp_blk3,
  output logic [POS_W-1:0]   disp_pos,
  output logic [SCORE_W-1:0] disp_score,
  output logic               disp_game_over,
  output logic               blink_on,
  output logic               commit_pulse,
  output logic [15:0]        frame_cnt
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  fsm_state_t state, state_nxt;
  snapshot_t  staging;
  snapshot_t  disp;
  logic       vs_start;
  logic       capture;
  logic       commit;
  logic [7:0] blink_cnt;
  logic       blink_phase;

  vsync_edge_det #(
    .VS_ACTIVE_LOW(VS_ACTIVE_LOW)
  ) u_vsync_edge_det (
    .clk     (clk),
    .reset   (reset),
    .vga_vs  (vga_vs),
    .vs_start(vs_start)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake decode; capture takes priority over a same-cycle
  // vsync because in IDLE there is nothing staged to commit.
  always_comb begin
    state_nxt = state;
    upd_ready = 1'b0;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        upd_ready = 1'b1;
        if (upd_valid) begin
          capture   = 1'b1;
          state_nxt = HELD;
        end
      end
      HELD: begin
        if (vs_start) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Staging register: loaded only on an accepted handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging <= '0;
    end else if (capture) begin
      staging <= '{grid: upd_grid, blk1: upd_blk1, blk2: upd_blk2,
                   blk3: upd_blk3, pos: upd_pos, score: upd_score,
                   game_over: upd_game_over};
    end
  end

  // Display registers and the matching one-cycle commit pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp         <= '0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= commit;
      if (commit) disp <= staging;
    end
  end

  // Frame counter counts every vsync start, wrapping naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         frame_cnt <= '0;
    else if (vs_start) frame_cnt <= frame_cnt + 16'd1;
  end

  // Blink timing keys off the pre-commit game-over flag. While that flag is
  // low the counter is held at 0 with phase 1, which also makes a 0->1 commit
  // start with the overlay visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!disp.game_over) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (vs_start) begin
      if (blink_cnt >= BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  assign disp_grid      = disp.grid;
  assign disp_blk1      = disp.blk1;
  assign disp_blk2      = disp.blk2;
  assign disp_blk3      = disp.blk3;
  assign disp_pos       = disp.pos;
  assign disp_score     = disp.score;
  assign disp_game_over = disp.game_over;
  assign blink_on       = disp.game_over & blink_phase;

endmodule : frame_commit_ctrl
`default_nettype wire

// File: doc/frame_commit_ctrl.md
Name: frame_commit_ctrl

Overview:
- Sits between game logic and vga_controller.
- Accepts complete game-state snapshots (grid, three pending blocks, block positions, score, game_over) over a valid/ready handshake and stages them.
- Commits the staged snapshot to its display outputs only at the start of vertical sync, so a frame never shows a mix of old and new state.
- Also generates a frame counter and a game-over blink phase for the renderer.

Parameters:
- BLINK_FRAMES, 30, frames per blink half-period (range 1..255).
- VS_ACTIVE_LOW, 1, polarity of vga_vs; 1 = sync pulse is low.

Ports:
- clk  in  1  pixel clock, same domain as vga_timing_640x480.
- reset  in  1  asynchronous, active-high.
- vga_vs  in  1  vertical sync from timing generator, same clock domain.
- upd_valid  in  1  snapshot offered.
- upd_ready  out  1  snapshot accepted when upd_valid && upd_ready.
- upd_grid  in  64  placed-cell bitmap, bit = row*8+col.
- upd_blk1, upd_blk2, upd_blk3  in  64 each  pending block shape bitmaps.
- upd_pos  in  18  {b3y,b3x,b2y,b2x,b1y,b1x}, 3 bits each.
- upd_score  in  8  score.
- upd_game_over  in  1  game-over flag.
- disp_grid, disp_blk1, disp_blk2, disp_blk3  out  64 each  committed state.
- disp_pos  out  18  committed positions, same packing as upd_pos.
- disp_score  out  8  committed score.
- disp_game_over  out  1  committed flag.
- blink_on  out  1  disp_game_over && blink_phase; renderer shows the overlay when high.
- commit_pulse  out  1  one-cycle pulse on the cycle the display registers load.
- frame_cnt  out  16  count of vsync-start events, wraps 0xFFFF->0.

Behaviour:
- Reset (async): all disp_* = 0, blink_on = 0, commit_pulse = 0, frame_cnt = 0, state = IDLE, staging = 0, blink counter = 0, blink_phase = 1.
  - The vs history register resets to the inactive level, so no spurious edge follows reset release.
  - upd_valid is ignored while reset is asserted.
- vs_start: one-cycle internal strobe on the transition of vga_vs from inactive to active, per VS_ACTIVE_LOW.
- FSM, two states:
  - IDLE: upd_ready = 1. On upd_valid, latch all upd_* into staging and go to HELD.
  - HELD: upd_ready = 0. On vs_start, copy staging to disp_* and go to IDLE. commit_pulse and the new disp_* values are visible on the cycle after the vs_start cycle.
- upd_ready is a combinational decode of state; no ready→valid dependency.
- Latency from accept to display: 1 to ~1 frame + 1 cycle. Exactly one snapshot is outstanding at a time.
- Capture and vs_start in the same cycle (IDLE): capture wins. The commit happens at the *next* vs_start; the current frame keeps the old state.
- Frames with no pending snapshot: disp_* hold their values, commit_pulse stays 0.
- frame_cnt: increments on every vs_start regardless of state, 16-bit wrap.
- Blink counter, 8-bit, advances on each vs_start while disp_game_over = 1:
  - When it reaches BLINK_FRAMES-1 it returns to 0 and blink_phase toggles.
  - A commit that changes disp_game_over from 0 to 1 forces counter = 0 and blink_phase = 1, so the overlay starts visible.
  - While disp_game_over = 0: counter = 0 and blink_phase = 1.
- Commit and blink update on the same vs_start: the blink logic uses the pre-commit disp_game_over. The 0→1 force applies on the commit cycle.
- Reset mid-HELD: staging is discarded, the FSM returns to IDLE, and no commit occurs.
- Values on upd_* while not accepted are don't-care and are never sampled.

Decomposition:
- Shared package (display_pkg):
  - GRID_W = 64, POS_W = 18, SCORE_W = 8.
  - Position field offsets: B1X = 0, B1Y = 3, B2X = 6, B2Y = 9, B3X = 12, B3Y = 15.
  - FSM state encoding IDLE = 0, HELD = 1.
- One sub-module: vsync_edge_det. It holds the polarity parameter and the history register and produces vs_start.
- Staging, commit and blink logic stay in the top module.

Test Plan:
- Reset release with vga_vs held at inactive level → no vs_start, frame_cnt = 0, upd_ready = 1, disp_grid = 0.
- Accept snapshot with upd_grid = 64'h00000000000000FF, upd_score = 8'd12 mid-frame → upd_ready = 0 next cycle, disp unchanged until the vs falling edge. On the cycle after that edge: disp_grid = 64'hFF, disp_score = 12, commit_pulse high for exactly 1 cycle, upd_ready = 1.
- upd_valid asserted on the same cycle as the vs falling edge with grid = 64'h1 → no commit that frame (commit_pulse = 0). Commit occurs one frame later; frame_cnt advances by 2 between accept and commit.
- Hold upd_valid = 1 continuously with incrementing score → exactly one accept per frame, disp_score steps by 1 per frame, no snapshot lost or duplicated.
- Commit game_over = 1 with BLINK_FRAMES = 2 → blink_on = 1 for 2 frames, 0 for 2 frames, repeating. Committing game_over = 0 → blink_on = 0 immediately on the commit cycle.
- Assert reset while HELD with staged grid = 64'hAAAA → after release, disp_grid = 0, state IDLE, no commit_pulse on the following vs edges.
